// File: rtl/data_serializer.sv
// Wide-to-narrow serializer: one IN_WIDTH word in, up to RATIO OUT_WIDTH slices out,
// with partial-word counts, selectable slice order and frame-end propagation.
module data_serializer #(
  parameter  int IN_WIDTH  = 64,
  parameter  int OUT_WIDTH = 8,
  parameter  int MSB_FIRST = 0,
  localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
  localparam int CW        = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 validIn,
  output logic                 readyIn,
  input  logic [IN_WIDTH-1:0]  inData,
  input  logic [CW-1:0]        inCount,
  input  logic                 inLast,
  output logic                 validOut,
  input  logic                 readyOut,
  output logic [OUT_WIDTH-1:0] outData,
  output logic                 outLast,
  output logic                 outFirst,
  output logic                 dbgState
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and ready may depend combinationally on the far side's ready.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                                state_q, state_d;
  logic [IN_WIDTH-1:0]                   hold_q;
  logic [CW-1:0]                         idx_q;
  logic [CW-1:0]                         cnt_q;
  logic                                  last_q;
  logic                                  load;
  logic                                  advance;
  logic                                  out_xfer;
  logic                                  final_slice;
  logic [CW-1:0]                         sel;
  logic [RATIO-1:0][OUT_WIDTH-1:0]       slices;

  assign validOut    = (state_q == BUSY);
  assign final_slice = (idx_q == cnt_q);
  assign out_xfer    = validOut && readyOut;
  // Accepting on the final slice's transfer cycle removes the bubble between words.
  assign readyIn     = (state_q == IDLE) || (out_xfer && final_slice);
  assign dbgState    = state_q;

  assign outFirst = validOut && (idx_q == '0);
  assign outLast  = validOut && last_q && final_slice;

  assign slices  = hold_q;
  assign sel     = (MSB_FIRST != 0) ? (CW'(RATIO - 1) - idx_q) : idx_q;
  assign outData = slices[sel];

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (validIn) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (out_xfer) begin
          if (final_slice) begin
            if (validIn) load    = 1'b1;
            else         state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        hold_q <= inData;
        cnt_q  <= inCount;
        last_q <= inLast;
        idx_q  <= '0;
      end else if (advance) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_serializer.sv
// Directed bench for data_serializer: one LSB-first and one MSB-first instance share stimulus;
// a vector table covers single words, hand sequences cover streaming, stalls and reset.
module tb_data_serializer;

  localparam int IW = 64;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [IW-1:0] in_data;
  logic [2:0]    in_count;
  logic          in_last;
  logic          ready_out;

  logic          ready_in_l, valid_out_l, out_last_l, out_first_l, dbg_l;
  logic [OW-1:0] out_data_l;
  logic          ready_in_m, valid_out_m, out_last_m, out_first_m, dbg_m;
  logic [OW-1:0] out_data_m;

  int n_cmp = 0;
  int n_bad = 0;

  logic [OW-1:0] exp_q[$];

  typedef struct {
    logic [63:0] data;
    logic [2:0]  count;
    logic        last;
    logic [63:0] exp_l;
    logic [63:0] exp_m;
  } vec_t;

  vec_t vecs[5];

  data_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .validIn(valid_in), .readyIn(ready_in_l),
    .inData(in_data), .inCount(in_count), .inLast(in_last),
    .validOut(valid_out_l), .readyOut(ready_out), .outData(out_data_l),
    .outLast(out_last_l), .outFirst(out_first_l), .dbgState(dbg_l)
  );

  data_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .validIn(valid_in), .readyIn(ready_in_m),
    .inData(in_data), .inCount(in_count), .inLast(in_last),
    .validOut(valid_out_m), .readyOut(ready_out), .outData(out_data_m),
    .outLast(out_last_m), .outFirst(out_first_m), .dbgState(dbg_m)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents a word at a negedge and returns at the negedge after it was accepted.
  task automatic send_word(input logic [63:0] d, input logic [2:0] c, input logic l);
    int t;
    @(negedge clk);
    valid_in = 1'b1;
    in_data  = d;
    in_count = c;
    in_last  = l;
    #1;
    t = 0;
    while (!ready_in_l && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t == 20) check("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  initial begin
    logic [63:0] el, em;
    int got;

    vecs[0] = '{64'h0706050403020100, 3'd7, 1'b1, 64'h0706050403020100, 64'h0001020304050607};
    vecs[1] = '{64'hFFEEDDCCBBAA9988, 3'd2, 1'b1, 64'h0000000000AA9988, 64'h0000000000DDEEFF};
    vecs[2] = '{64'hFFEEDDCCBBAA9988, 3'd0, 1'b1, 64'h0000000000000088, 64'h00000000000000FF};
    vecs[3] = '{64'h0123456789ABCDEF, 3'd7, 1'b0, 64'h0123456789ABCDEF, 64'hEFCDAB8967452301};
    vecs[4] = '{64'hA1B2C3D4E5F60718, 3'd4, 1'b1, 64'h000000D4E5F60718, 64'h000000E5D4C3B2A1};

    // reset
    reset = 1'b1; valid_in = 1'b0; in_data = '0; in_count = '0; in_last = 1'b0; ready_out = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valid", valid_out_l, 0);
    check("rst_ready", ready_in_l, 1);
    check("rst_data", out_data_l, 0);
    check("rst_first", out_first_l, 0);
    check("rst_last", out_last_l, 0);
    check("rst_state", dbg_l, 0);

    // table of single words
    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].data, vecs[i].count, vecs[i].last);
      el = vecs[i].exp_l;
      em = vecs[i].exp_m;
      for (int k = 0; k <= int'(vecs[i].count); k++) begin
        ready_out = 1'b1;
        #1;
        check($sformatf("v%0d_valid_%0d", i, k), valid_out_l, 1);
        check($sformatf("v%0d_lsb_%0d", i, k), out_data_l, el[k*8 +: 8]);
        check($sformatf("v%0d_msb_%0d", i, k), out_data_m, em[k*8 +: 8]);
        check($sformatf("v%0d_first_%0d", i, k), out_first_l, k == 0);
        check($sformatf("v%0d_last_%0d", i, k), out_last_l, vecs[i].last && k == int'(vecs[i].count));
        check($sformatf("v%0d_mlast_%0d", i, k), out_last_m, vecs[i].last && k == int'(vecs[i].count));
        check($sformatf("v%0d_rdyin_%0d", i, k), ready_in_l, k == int'(vecs[i].count));
        @(negedge clk);
      end
      #1;
      check($sformatf("v%0d_idle", i), valid_out_l, 0);
    end

    // back-to-back words with validIn held
    @(negedge clk);
    valid_in = 1'b1; in_data = {8{8'h11}}; in_count = 3'd7; in_last = 1'b0; ready_out = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin in_data = {8{8'h22}}; in_last = 1'b1; end
      if (k == 8) valid_in = 1'b0;
      #1;
      check($sformatf("b2b_valid_%0d", k), valid_out_l, 1);
      check($sformatf("b2b_data_%0d", k), out_data_l, (k < 8) ? 8'h11 : 8'h22);
      check($sformatf("b2b_first_%0d", k), out_first_l, k == 0 || k == 8);
      check($sformatf("b2b_last_%0d", k), out_last_l, k == 15);
      check($sformatf("b2b_rdyin_%0d", k), ready_in_l, k == 7 || k == 15);
    end
    @(negedge clk);
    #1;
    check("b2b_idle", valid_out_l, 0);

    // backpressure: readyOut 1,0,0,1,0,0,...
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(k));
    send_word(64'h0706050403020100, 3'd7, 1'b1);
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      ready_out = (cyc % 3 == 0);
      #1;
      check($sformatf("bp_valid_%0d", cyc), valid_out_l, 1);
      check($sformatf("bp_data_%0d", cyc), out_data_l, exp_q[0]);
      check($sformatf("bp_first_%0d", cyc), out_first_l, got == 0);
      check($sformatf("bp_last_%0d", cyc), out_last_l, got == 7);
      check($sformatf("bp_rdyin_%0d", cyc), ready_in_l, ready_out && got == 7);
      if (ready_out) begin
        void'(exp_q.pop_front());
        got++;
      end
      @(negedge clk);
    end
    ready_out = 1'b1;
    #1;
    check("bp_count", got, 8);
    check("bp_queue", exp_q.size(), 0);
    check("bp_idle", valid_out_l, 0);

    // reset in the middle of a word (idx=4), with an output transfer in the same cycle
    send_word(64'h0706050403020100, 3'd7, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ready_out = 1'b1;
      #1;
      check($sformatf("mr_data_%0d", k), out_data_l, 8'(k));
      @(negedge clk);
    end
    ready_out = 1'b1;
    reset = 1'b1;
    #1;
    check("mr_idx4", out_data_l, 8'h04);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_valid", valid_out_l, 0);
    check("mr_ready", ready_in_l, 1);
    check("mr_data0", out_data_l, 0);
    check("mr_lastflag", out_last_l, 0);
    send_word(64'h8877665544332211, 3'd1, 1'b1);
    #1;
    check("mr_s0_data", out_data_l, 8'h11);
    check("mr_s0_first", out_first_l, 1);
    check("mr_s0_last", out_last_l, 0);
    @(negedge clk);
    #1;
    check("mr_s1_data", out_data_l, 8'h22);
    check("mr_s1_last", out_last_l, 1);
    @(negedge clk);
    #1;
    check("mr_idle", valid_out_l, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
